// File: rtl/sccb_pkg.sv
// sccb_pkg: shared state encoding and camera address for the SCCB write arbiter
package sccb_pkg;
    typedef enum logic [2:0] {IDLE, START, SLV_ADDR, REG_ADDR, REG_DATA, DONE} state_e;
    localparam logic [7:0] OV7670_WR_ADDR = 8'h42;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin winner search starting at a rotating pointer
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IW-1:0]      gnt_idx,
    output logic               gnt_any
);
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_idx;

    // scan from the pointer downwards in priority so the nearest requester wins last
    always_comb begin
        w_idx   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = IW'((int'(r_ptr) + k) % NUM_REQ);
            if (req[w_idx]) begin
                gnt_idx = w_idx;
                gnt_any = 1'b1;
            end
        end
        gnt_onehot = gnt_any ? NUM_REQ'(1) << gnt_idx : '0;
    end

    // pointer moves just past the winner, only when a grant is taken
    always_ff @(posedge clk) begin
        if (reset)
            r_ptr <= '0;
        else if (accept)
            r_ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
endmodule

// File: rtl/sccb_write_arbiter.sv
// sccb_write_arbiter: shares one byte-level I2C master among SCCB register writers
// Optional byte watchdog enabled by defining SCCB_ARB_TIMEOUT_EN.
module sccb_write_arbiter
    import sccb_pkg::*;
#(
    parameter int          NUM_REQ        = 2,
    parameter logic [7:0]  SLV_ADDR       = OV7670_WR_ADDR,
    parameter int          TIMEOUT_CYCLES = 2_000_000,
    localparam int         IW             = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_reg_addr,
    input  logic [8*NUM_REQ-1:0] req_reg_data,
    output logic                 rsp_valid,
    output logic [IW-1:0]        rsp_id,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 I2C_en,
    output logic                 I2C_start,
    output logic                 I2C_stop,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    input  logic                 ack_error
);
    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("sccb_write_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    state_e             r_state;
    logic [IW-1:0]      r_gnt_id;
    logic [7:0]         r_reg_addr;
    logic [7:0]         r_reg_data;
    logic [NUM_REQ-1:0] w_gnt_onehot;
    logic [IW-1:0]      w_gnt_idx;
    logic               w_gnt_any;
    logic               w_accept;
    logic               w_byte;
    logic               w_timeout;
    logic               w_fail;

    assign w_accept  = (r_state == IDLE) && w_gnt_any;
    assign req_ready = w_accept ? w_gnt_onehot : '0;
    assign w_byte    = (r_state == sccb_pkg::SLV_ADDR) || (r_state == REG_ADDR) || (r_state == REG_DATA);
    assign w_fail    = w_byte && (ack_error || w_timeout);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk        (clk),
        .reset      (reset),
        .req        (req_valid),
        .accept     (w_accept),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .gnt_any    (w_gnt_any)
    );

`ifdef SCCB_ARB_TIMEOUT_EN
    logic [31:0] r_wdog;

    assign w_timeout = (r_wdog == 32'(TIMEOUT_CYCLES - 1));

    // byte watchdog restarts outside byte states and whenever a byte state is left
    always_ff @(posedge clk) begin
        if (reset || !w_byte || w_fail || tx_done)
            r_wdog <= '0;
        else
            r_wdog <= r_wdog + 32'd1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    // transaction sequencer; outputs are loaded on entry to each state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_gnt_id   <= '0;
            r_reg_addr <= '0;
            r_reg_data <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            I2C_en     <= 1'b0;
            I2C_start  <= 1'b0;
            I2C_stop   <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_state    <= START;
                    r_gnt_id   <= w_gnt_idx;
                    r_reg_addr <= req_reg_addr[w_gnt_idx*8 +: 8];
                    r_reg_data <= req_reg_data[w_gnt_idx*8 +: 8];
                    busy       <= 1'b1;
                    I2C_en     <= 1'b1;
                    I2C_start  <= 1'b1;
                    tx_data    <= SLV_ADDR;
                end
                START: begin
                    r_state   <= sccb_pkg::SLV_ADDR;
                    I2C_start <= 1'b0;
                end
                sccb_pkg::SLV_ADDR: if (tx_done) begin
                    r_state <= REG_ADDR;
                    tx_data <= r_reg_addr;
                end
                REG_ADDR: if (tx_done) begin
                    r_state  <= REG_DATA;
                    tx_data  <= r_reg_data;
                    I2C_stop <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    rsp_id  <= '0;
                    rsp_err <= 1'b0;
                end
                default: r_state <= r_state;
            endcase
            // error beats tx_done; the last byte or any failure closes the transaction
            if (w_fail || (r_state == REG_DATA && tx_done)) begin
                r_state   <= DONE;
                rsp_valid <= 1'b1;
                rsp_id    <= r_gnt_id;
                rsp_err   <= w_fail;
                I2C_en    <= 1'b0;
                I2C_stop  <= 1'b0;
                tx_data   <= 8'h00;
            end
        end
    end
endmodule
